sram_arbiter_2port: RTL
=======================

# sram_arbiter_2port

Two-requester arbiter sharing one single-port synchronous SRAM (`sram_sync` with byte enables, 1-cycle read latency) between a high-bandwidth master (e.g. the processor's AHB-lite SRAM interface) and a secondary master (e.g. display/DMA fetch). Each cycle it selects at most one request by round-robin, drives the SRAM address/write-enable/write-data combinationally from the winner, and returns a read-valid strobe to the winner one cycle later. A lock mechanism gives one requester exclusive back-to-back access for atomic sequences, with a timeout so a stalled owner cannot starve the other port.

## Interface
Parameters:
- `W_DATA`, 32, data width in bits; multiple of 8.
- `W_ADDR`, 11, SRAM word-address width.
- `LOCK_TIMEOUT`, 16, idle cycles after which a held lock is forcibly released; must be ≥1.

Derived: `W_BYTES = W_DATA/8`; timeout counter width `$clog2(LOCK_TIMEOUT+1)`.

Ports:
- `clk` in 1: sole clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pN_req` in 1 (N=0,1): access request; held with payload stable until `pN_gnt`.
- `pN_write` in 1: 1 = write, 0 = read.
- `pN_addr` in W_ADDR: word address.
- `pN_wdata` in W_DATA: write data.
- `pN_wmask` in W_BYTES: byte-lane write enables (ignored for reads).
- `pN_lock` in 1: request/keep exclusive ownership after this access.
- `pN_gnt` out 1: access issued to SRAM this cycle (combinational).
- `pN_rvalid` out 1: `sram_rdata` holds this port's read data (registered).
- `rdata` out W_DATA: `sram_rdata` passed through, shared by both ports, qualified by `pN_rvalid`.
- `lock_timeout_err` out 1: one-cycle pulse when a lock is forcibly released.
- `sram_addr` out W_ADDR, `sram_wen` out W_BYTES, `sram_wdata` out W_DATA, `sram_rdata` in W_DATA: SRAM macro port.

## Operation
- Per cycle at most one of `p0_gnt`/`p1_gnt` is high; a grant occurs only when that port's `req` is high.
- Grant is combinational on `req`, `lock_state`, `last_grant`. Requesters must not derive `req` combinationally from `gnt`.
- State `last_grant` (1 bit):
  - updated to the granted port on every grant;
  - on simultaneous requests in UNLOCKED, the port ≠ `last_grant` wins;
  - a lone request always wins.
- Lock FSM `lock_state`:
  - UNLOCKED: round-robin as above. A grant with `pN_lock=1` moves to LOCKEDn.
  - LOCKEDn: only port n may be granted; the other port's req is stalled.
    - A port-n grant with `pN_lock=0` returns to UNLOCKED; the access itself completes.
    - A port-n grant with lock=1 stays in LOCKEDn.
- Timeout counter:
  - cleared on entry to LOCKEDn and on every port-n grant;
  - increments each LOCKEDn cycle with `pN_req=0`;
  - on reaching LOCKEDn with count = LOCKED_TIMEOUT-1 and `pN_req=0`: next state UNLOCKED, counter cleared, `lock_timeout_err` pulses the following cycle.
  - In the cycle after timeout release, normal round-robin applies; the former owner has no priority.
- SRAM drive from the winner:
  - `sram_addr = pN_addr`, `sram_wdata = pN_wdata`;
  - `sram_wen = pN_wmask` if write, else 0.
- With no grant: `sram_wen = 0`; `sram_addr`/`sram_wdata` follow port 0 (don't-care, but must not toggle `wen`).
- A write with `wmask=0` is granted normally and is a no-op.
- Read grant to port n sets `pN_rvalid=1` next cycle; writes never raise rvalid.
- Reset (`rst` high):
  - all `gnt` and `sram_wen` forced low combinationally;
  - next edge: `lock_state=UNLOCKED`, `last_grant=1` (port 0 wins first tie), counter 0, both `rvalid`=0, `lock_timeout_err`=0.
  - Reset mid-lock or during an outstanding read discards both; the read's rvalid must not appear after reset.

## Timing
- Issue throughput: one access per cycle, no bubbles between back-to-back grants, including port switches and read→write turnarounds.
- Read latency: grant in cycle T, `rdata` valid with `pN_rvalid` in cycle T+1.
- Write: committed at the end of the grant cycle; a read of the same address granted in T+1 returns the new data in T+2.
- Lock entry and exit take effect from the cycle after the granting access.
- Registered outputs: `pN_rvalid`, `lock_timeout_err`. Combinational outputs: `gnt`, `sram_*`.

## Test plan
- **Reset defaults:** hold `rst` 2 cycles with both req=1 → both gnt=0, `sram_wen`=0. Release → first cycle `p0_gnt`=1.
- **Round-robin:** both ports read continuously, 8 cycles → grants alternate 0,1,0,1…; each rvalid arrives one cycle after its grant with the correct data; zero idle cycles.
- **Byte-lane write then read:** p1 writes 0xAABBCCDD mask 4'b1111 at 0x010, then 0x11 mask 4'b0001 → p0 read of 0x010 returns 0xAABBCC11. A `wmask=0` write leaves it unchanged.
- **Lock exclusivity:** p0 issues 3 accesses with lock=1,1,0 while p1 requests continuously → p1 is stalled for exactly those 3 grants and is granted the next cycle.
- **Lock timeout:** p1 locks, then drops req with LOCK_TIMEOUT=16 → p0 is granted exactly 16 cycles later; `lock_timeout_err` pulses once. If p1 re-requests at idle count 15, the counter clears and no error occurs.
- **Reset mid-operation:** assert `rst` in the cycle after a p0 read grant while LOCKED0 → no `p0_rvalid`, state UNLOCKED, and after reset p0 wins the first tie.

Source files
------------

// File: rtl/sram_arbiter_2port.sv
// ---------------------------------------------------------------------------
// sram_arbiter_2port
//
// Shares one single-port synchronous SRAM (byte write enables, 1-cycle read
// latency) between two requesters. Each cycle at most one request is issued
// to the SRAM, chosen by round-robin. A requester may lock the SRAM for
// back-to-back exclusive access; an idle lock owner is forcibly released
// after LOCK_TIMEOUT cycles without a request.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   pN_req/_write/_addr   request, direction, word address      (N = 0, 1)
//   pN_wdata/_wmask       write data and byte-lane write enables
//   pN_lock               hold exclusive ownership after this access
//   pN_gnt                access issued to the SRAM this cycle (comb.)
//   pN_rvalid             rdata carries this port's read data (registered)
//   rdata                 SRAM read data, shared, qualified by pN_rvalid
//   lock_timeout_err      one-cycle pulse after a forced lock release
//   sram_addr/_wen/_wdata SRAM drive from the winner (comb.)
//   sram_rdata            SRAM read data
//
// Lock FSM
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_UNLOCKED | round-robin between both ports
//   ST_LOCKED0  | only port 0 may be granted, idle timer running
//   ST_LOCKED1  | only port 1 may be granted, idle timer running
// ---------------------------------------------------------------------------
module sram_arbiter_2port #(
    parameter int W_DATA       = 32,
    parameter int W_ADDR       = 11,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  p0_req,
    input  logic                  p0_write,
    input  logic [W_ADDR-1:0]     p0_addr,
    input  logic [W_DATA-1:0]     p0_wdata,
    input  logic [W_DATA/8-1:0]   p0_wmask,
    input  logic                  p0_lock,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,

    input  logic                  p1_req,
    input  logic                  p1_write,
    input  logic [W_ADDR-1:0]     p1_addr,
    input  logic [W_DATA-1:0]     p1_wdata,
    input  logic [W_DATA/8-1:0]   p1_wmask,
    input  logic                  p1_lock,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,

    output logic [W_DATA-1:0]     rdata,
    output logic                  lock_timeout_err,

    output logic [W_ADDR-1:0]     sram_addr,
    output logic [W_DATA/8-1:0]   sram_wen,
    output logic [W_DATA-1:0]     sram_wdata,
    input  logic [W_DATA-1:0]     sram_rdata
);

    localparam int W_BYTES = W_DATA / 8;
    localparam int W_CNT   = $clog2(LOCK_TIMEOUT + 1);

    // The idle timer counts down from LOCK_TIMEOUT-1; an idle cycle seen at
    // zero is the LOCK_TIMEOUT-th idle cycle and releases the lock.
    localparam logic [W_CNT-1:0] LOCK_CNT_LOAD = W_CNT'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED0  = 2'd1,
        ST_LOCKED1  = 2'd2
    } lock_state_t;

    lock_state_t        r_lock_state;
    logic               r_last_grant;
    logic [W_CNT-1:0]   r_lock_cnt;
    logic               r_p0_rvalid;
    logic               r_p1_rvalid;
    logic               r_lock_timeout_err;

    logic               w_p0_gnt;
    logic               w_p1_gnt;
    logic [W_BYTES-1:0] w_sram_wen;

    // Grant decode. On a tie in ST_UNLOCKED the port that did not win last
    // time goes first.
    always_comb begin
        w_p0_gnt = 1'b0;
        w_p1_gnt = 1'b0;
        if (!rst) begin
            case (r_lock_state)
                ST_LOCKED0: w_p0_gnt = p0_req;
                ST_LOCKED1: w_p1_gnt = p1_req;
                default: begin
                    if (p0_req && p1_req) begin
                        w_p0_gnt = r_last_grant;
                        w_p1_gnt = ~r_last_grant;
                    end else begin
                        w_p0_gnt = p0_req;
                        w_p1_gnt = p1_req;
                    end
                end
            endcase
        end
    end

    // Without a grant the address/data mux rests on port 0 and only the
    // write enables are forced off.
    always_comb begin
        w_sram_wen = '0;
        if (w_p0_gnt && p0_write) begin
            w_sram_wen = p0_wmask;
        end else if (w_p1_gnt && p1_write) begin
            w_sram_wen = p1_wmask;
        end
    end

    assign sram_addr  = w_p1_gnt ? p1_addr  : p0_addr;
    assign sram_wdata = w_p1_gnt ? p1_wdata : p0_wdata;
    assign sram_wen   = w_sram_wen;

    assign p0_gnt = w_p0_gnt;
    assign p1_gnt = w_p1_gnt;
    assign rdata  = sram_rdata;

    // A read granted just before reset must not be reported, even in the
    // reset cycle itself, so the strobes are masked while rst is high.
    assign p0_rvalid        = r_p0_rvalid & ~rst;
    assign p1_rvalid        = r_p1_rvalid & ~rst;
    assign lock_timeout_err = r_lock_timeout_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_state       <= ST_UNLOCKED;
            r_last_grant       <= 1'b1;
            r_lock_cnt         <= '0;
            r_p0_rvalid        <= 1'b0;
            r_p1_rvalid        <= 1'b0;
            r_lock_timeout_err <= 1'b0;
        end else begin
            r_p0_rvalid        <= w_p0_gnt & ~p0_write;
            r_p1_rvalid        <= w_p1_gnt & ~p1_write;
            r_lock_timeout_err <= 1'b0;

            if (w_p0_gnt) begin
                r_last_grant <= 1'b0;
            end else if (w_p1_gnt) begin
                r_last_grant <= 1'b1;
            end

            case (r_lock_state)
                ST_UNLOCKED: begin
                    if (w_p0_gnt && p0_lock) begin
                        r_lock_state <= ST_LOCKED0;
                        r_lock_cnt   <= LOCK_CNT_LOAD;
                    end else if (w_p1_gnt && p1_lock) begin
                        r_lock_state <= ST_LOCKED1;
                        r_lock_cnt   <= LOCK_CNT_LOAD;
                    end
                end

                // In a locked state a missing grant means the owner is idle.
                ST_LOCKED0: begin
                    if (w_p0_gnt) begin
                        r_lock_cnt <= LOCK_CNT_LOAD;
                        if (!p0_lock) begin
                            r_lock_state <= ST_UNLOCKED;
                        end
                    end else if (r_lock_cnt == '0) begin
                        r_lock_state       <= ST_UNLOCKED;
                        r_lock_cnt         <= '0;
                        r_lock_timeout_err <= 1'b1;
                    end else begin
                        r_lock_cnt <= r_lock_cnt - 1'b1;
                    end
                end

                ST_LOCKED1: begin
                    if (w_p1_gnt) begin
                        r_lock_cnt <= LOCK_CNT_LOAD;
                        if (!p1_lock) begin
                            r_lock_state <= ST_UNLOCKED;
                        end
                    end else if (r_lock_cnt == '0) begin
                        r_lock_state       <= ST_UNLOCKED;
                        r_lock_cnt         <= '0;
                        r_lock_timeout_err <= 1'b1;
                    end else begin
                        r_lock_cnt <= r_lock_cnt - 1'b1;
                    end
                end

                default: begin
                    r_lock_state <= ST_UNLOCKED;
                    r_lock_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
